// File: rtl/stats_record_arbiter.sv
// stats_record_arbiter
//   Merges per-channel response-statistics events onto one registered
//   valid/ready statistics-sink port. Each event is stamped with a shared
//   64-bit free-running cycle counter and buffered in a per-channel FIFO.
//   A round-robin arbiter drains the FIFOs into a one-stage output
//   register. Producers never stall: an event that finds its FIFO full
//   (and not being popped in the same cycle) is dropped and flagged.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_rd/in_wr       per-channel event strobe and flags
//   in_request_id/in_addr      per-channel ID and address (channel i at [i*W +: W])
//   in_wdata/in_data           per-channel write / response data
//   out_valid/out_ready        output handshake
//   out_chan, out_rd, out_wr   source channel and record flags
//   out_request_id, out_addr   record ID and address
//   out_wdata, out_data        record data
//   out_cycle                  timestamp captured at enqueue
//   global_cycle               free-running cycle counter
//   overflow                   sticky per-channel drop flags
//   drop_count                 per-channel saturating drop counters, present
//                              only when STATS_ARB_DROP_COUNT_EN is defined
//
// Build option: define STATS_ARB_DROP_COUNT_EN to add the drop_count port.

module stats_record_arbiter #(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 4,
    parameter int ID_W   = 32,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH-1:0]          in_rd,
    input  logic [NUM_CH-1:0]          in_wr,
    input  logic [NUM_CH*ID_W-1:0]     in_request_id,
    input  logic [NUM_CH*ADDR_W-1:0]   in_addr,
    input  logic [NUM_CH*DATA_W-1:0]   in_wdata,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(NUM_CH)-1:0]  out_chan,
    output logic                       out_rd,
    output logic                       out_wr,
    output logic [ID_W-1:0]            out_request_id,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [DATA_W-1:0]          out_wdata,
    output logic [DATA_W-1:0]          out_data,
    output logic [63:0]                out_cycle,
    output logic [63:0]                global_cycle,
    output logic [NUM_CH-1:0]          overflow
`ifdef STATS_ARB_DROP_COUNT_EN
    ,
    output logic [NUM_CH*32-1:0]       drop_count
`endif
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int REC_W = 2 + ID_W + ADDR_W + 2 * DATA_W + 64;

    logic [NUM_CH-1:0]             empty;
    logic [NUM_CH-1:0]             full;
    logic [NUM_CH-1:0]             push;
    logic [NUM_CH-1:0]             pop;
    logic [NUM_CH-1:0]             drop;
    logic [NUM_CH-1:0][REC_W-1:0]  head;

    logic [CH_W-1:0]               last_grant_reg;
    logic [CH_W-1:0]               grant;
    logic [CH_W-1:0]               cand;
    logic                          any_ready;
    logic                          load;

    // ------------------------------------------------------------------
    // Per-channel FIFOs. Pointers carry one extra wrap bit so that full
    // and empty are distinguishable with DEPTH entries in use.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [PTR_W-1:0] wr_ptr_reg;
        logic [PTR_W-1:0] rd_ptr_reg;
        logic [REC_W-1:0] mem [DEPTH];
        logic [REC_W-1:0] wr_rec;

        assign wr_rec = {in_rd[gi], in_wr[gi],
                         in_request_id[gi*ID_W +: ID_W],
                         in_addr[gi*ADDR_W +: ADDR_W],
                         in_wdata[gi*DATA_W +: DATA_W],
                         in_data[gi*DATA_W +: DATA_W],
                         global_cycle};

        assign empty[gi] = (wr_ptr_reg == rd_ptr_reg);
        assign full[gi]  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                           (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
        assign pop[gi]   = load && (grant == CH_W'(gi));
        // A pop in the same cycle frees the slot, so a full FIFO still
        // accepts the incoming event.
        assign push[gi]  = in_valid[gi] && (!full[gi] || pop[gi]);
        assign drop[gi]  = in_valid[gi] && full[gi] && !pop[gi];
        assign head[gi]  = mem[rd_ptr_reg[AW-1:0]];

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push[gi]) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                end
                if (pop[gi]) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                end
            end
        end

        // Storage has no reset; emptiness is defined purely by the pointers.
        always_ff @(posedge clk) begin
            if (push[gi]) begin
                mem[wr_ptr_reg[AW-1:0]] <= wr_rec;
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter: scan from last_grant+1 upward with wrap. The
    // scan uses only registered FIFO state, so there is no bypass from
    // in_valid to the output register.
    // ------------------------------------------------------------------
    always_comb begin
        grant     = '0;
        any_ready = 1'b0;
        cand      = last_grant_reg;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = (cand == CH_W'(NUM_CH - 1)) ? '0 : cand + 1'b1;
            if (!any_ready && !empty[cand]) begin
                any_ready = 1'b1;
                grant     = cand;
            end
        end
    end

    assign load = (!out_valid || out_ready) && any_ready;

    // ------------------------------------------------------------------
    // Output register. Fields only change on a load, so they stay stable
    // while the sink stalls.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_chan       <= '0;
            out_rd         <= 1'b0;
            out_wr         <= 1'b0;
            out_request_id <= '0;
            out_addr       <= '0;
            out_wdata      <= '0;
            out_data       <= '0;
            out_cycle      <= '0;
            // Channel 0 becomes the first candidate after reset.
            last_grant_reg <= CH_W'(NUM_CH - 1);
        end else if (load) begin
            out_valid      <= 1'b1;
            out_chan       <= grant;
            {out_rd, out_wr, out_request_id, out_addr,
             out_wdata, out_data, out_cycle} <= head[grant];
            last_grant_reg <= grant;
        end else if (out_ready) begin
            out_valid      <= 1'b0;
        end
    end

    // Free-running timestamp and sticky drop flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            global_cycle <= '0;
            overflow     <= '0;
        end else begin
            global_cycle <= global_cycle + 64'd1;
            overflow     <= overflow | drop;
        end
    end

`ifdef STATS_ARB_DROP_COUNT_EN
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_drop
        logic [31:0] cnt_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_reg <= '0;
            end else if (drop[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
                cnt_reg <= cnt_reg + 32'd1;
            end
        end

        assign drop_count[gi*32 +: 32] = cnt_reg;
    end
`endif

endmodule

// File: tb/tb_stats_record_arbiter.sv
// tb_stats_record_arbiter
//   Self-checking bench for stats_record_arbiter. A queue-based reference
//   model tracks FIFO contents, the output register, the round-robin
//   pointer, timestamps and drop accounting; every cycle the DUT outputs
//   are compared against it. Directed scenarios add fixed-value checks.

module tb_stats_record_arbiter;

    localparam int NUM_CH = 4;
    localparam int DEPTH  = 4;

    logic                   clk;
    logic                   reset;
    logic [NUM_CH-1:0]      in_valid;
    logic [NUM_CH-1:0]      in_rd;
    logic [NUM_CH-1:0]      in_wr;
    logic [NUM_CH*32-1:0]   in_request_id;
    logic [NUM_CH*32-1:0]   in_addr;
    logic [NUM_CH*32-1:0]   in_wdata;
    logic [NUM_CH*32-1:0]   in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [1:0]             out_chan;
    logic                   out_rd;
    logic                   out_wr;
    logic [31:0]            out_request_id;
    logic [31:0]            out_addr;
    logic [31:0]            out_wdata;
    logic [31:0]            out_data;
    logic [63:0]            out_cycle;
    logic [63:0]            global_cycle;
    logic [NUM_CH-1:0]      overflow;
`ifdef STATS_ARB_DROP_COUNT_EN
    logic [NUM_CH*32-1:0]   drop_count;
`endif

    stats_record_arbiter #(
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH),
        .ID_W   (32),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_rd          (in_rd),
        .in_wr          (in_wr),
        .in_request_id  (in_request_id),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_chan       (out_chan),
        .out_rd         (out_rd),
        .out_wr         (out_wr),
        .out_request_id (out_request_id),
        .out_addr       (out_addr),
        .out_wdata      (out_wdata),
        .out_data       (out_data),
        .out_cycle      (out_cycle),
        .global_cycle   (global_cycle),
        .overflow       (overflow)
`ifdef STATS_ARB_DROP_COUNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [2:0]  ch;
        logic        rd;
        logic        wr;
        logic [31:0] id;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;
        logic [63:0] cyc;
    } rec_t;

    rec_t         q [NUM_CH][$];
    rec_t         m_out;
    logic         m_valid;
    int           m_last;
    logic [63:0]  m_cyc;
    logic [NUM_CH-1:0] m_ovf;
    logic [31:0]  m_drops [NUM_CH];

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            q[c].delete();
            m_drops[c] = 0;
        end
        m_out   = '0;
        m_valid = 1'b0;
        m_last  = NUM_CH - 1;
        m_cyc   = 0;
        m_ovf   = '0;
    endtask

    // Applies one clock edge worth of behaviour using the inputs the bench
    // is currently driving.
    task automatic model_update();
        bit found;
        rec_t r;
        if (reset) begin
            model_reset();
            return;
        end
        found = 0;
        if (!m_valid || out_ready) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                int c;
                c = (m_last + k) % NUM_CH;
                if (!found && q[c].size() > 0) begin
                    found   = 1;
                    m_out   = q[c].pop_front();
                    m_valid = 1'b1;
                    m_last  = c;
                end
            end
            if (!found && out_ready) m_valid = 1'b0;
        end
        // A pop made above frees space for this cycle's event.
        for (int c = 0; c < NUM_CH; c++) begin
            if (in_valid[c]) begin
                if (q[c].size() < DEPTH) begin
                    r.ch    = 3'(c);
                    r.rd    = in_rd[c];
                    r.wr    = in_wr[c];
                    r.id    = in_request_id[c*32 +: 32];
                    r.addr  = in_addr[c*32 +: 32];
                    r.wdata = in_wdata[c*32 +: 32];
                    r.data  = in_data[c*32 +: 32];
                    r.cyc   = m_cyc;
                    q[c].push_back(r);
                end else begin
                    m_ovf[c] = 1'b1;
                    if (m_drops[c] != 32'hFFFF_FFFF) m_drops[c] = m_drops[c] + 1;
                end
            end
        end
        m_cyc = m_cyc + 1;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("global_cycle", global_cycle, m_cyc);
        chk("overflow", 64'(overflow), 64'(m_ovf));
`ifdef STATS_ARB_DROP_COUNT_EN
        for (int c = 0; c < NUM_CH; c++)
            chk("drop_count", 64'(drop_count[c*32 +: 32]), 64'(m_drops[c]));
`endif
        if (m_valid) begin
            chk("out_chan", 64'(out_chan), 64'(m_out.ch));
            chk("out_rd", 64'(out_rd), 64'(m_out.rd));
            chk("out_wr", 64'(out_wr), 64'(m_out.wr));
            chk("out_request_id", 64'(out_request_id), 64'(m_out.id));
            chk("out_addr", 64'(out_addr), 64'(m_out.addr));
            chk("out_wdata", 64'(out_wdata), 64'(m_out.wdata));
            chk("out_data", 64'(out_data), 64'(m_out.data));
            chk("out_cycle", out_cycle, m_out.cyc);
        end
    endtask

    task automatic rand_inputs();
        for (int c = 0; c < NUM_CH; c++) begin
            in_rd[c] = 1'($urandom_range(0, 1));
            in_wr[c] = 1'($urandom_range(0, 1));
            in_request_id[c*32 +: 32] = $urandom;
            in_addr[c*32 +: 32]       = $urandom;
            in_wdata[c*32 +: 32]      = $urandom;
            in_data[c*32 +: 32]       = $urandom;
        end
    endtask

    // One clock cycle: drive, edge, update model, sample #1 later, compare.
    task automatic step(input logic rst, input logic [NUM_CH-1:0] v, input logic rdy);
        reset     = rst;
        in_valid  = v;
        out_ready = rdy;
        @(posedge clk);
        model_update();
        #1;
        check_all();
        in_valid = '0;
        rand_inputs();
    endtask

    int fair1 [4] = '{0, 1, 2, 3};
    int fair2 [4] = '{2, 3, 0, 1};
    int ch1_seen;

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        in_valid = '0;
        out_ready = 1'b0;
        rand_inputs();
        model_reset();

        // ---- reset state ----
        step(1, '0, 0);
        step(1, '0, 0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_global_cycle", global_cycle, 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_out_addr", 64'(out_addr), 64'd0);
        chk("rst_out_request_id", 64'(out_request_id), 64'd0);
        chk("rst_out_cycle", out_cycle, 64'd0);

        // ---- single event on channel 2 at global_cycle 5 ----
        for (int i = 0; i < 5; i++) step(0, '0, 1);
        in_request_id[2*32 +: 32] = 32'd7;
        in_addr[2*32 +: 32]       = 32'h100;
        in_rd[2] = 1'b1;
        in_wr[2] = 1'b0;
        step(0, 4'b0100, 1);
        chk("single_not_early", 64'(out_valid), 64'd0);
        step(0, '0, 1);
        chk("single_gc", global_cycle, 64'd7);
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_chan", 64'(out_chan), 64'd2);
        chk("single_id", 64'(out_request_id), 64'd7);
        chk("single_addr", 64'(out_addr), 64'h100);
        chk("single_rd", 64'(out_rd), 64'd1);
        chk("single_cycle", out_cycle, 64'd5);
        step(0, '0, 1);

        // ---- fairness ----
        step(1, '0, 1);
        step(0, 4'b1111, 1);
        step(0, '0, 1);
        for (int k = 0; k < 4; k++) begin
            chk("fair1_chan", 64'(out_chan), 64'(fair1[k]));
            step(0, '0, 1);
        end
        step(0, 4'b0010, 1);
        step(0, '0, 1);
        chk("fair_last1_chan", 64'(out_chan), 64'd1);
        step(0, 4'b1111, 1);
        step(0, '0, 1);
        for (int k = 0; k < 4; k++) begin
            chk("fair2_chan", 64'(out_chan), 64'(fair2[k]));
            step(0, '0, 1);
        end

        // ---- backpressure: stall 10 cycles with records pending ----
        step(0, 4'b1011, 1);
        step(0, '0, 1);
        for (int i = 0; i < 10; i++) step(0, '0, 0);
        for (int i = 0; i < 6; i++) step(0, '0, 1);
        chk("bp_drained", 64'(out_valid), 64'd0);

        // ---- overflow on channel 1 ----
        step(1, '0, 0);
        step(0, 4'b0001, 0);                 // occupies the output register
        for (int i = 0; i < 4; i++) step(0, 4'b0010, 0);
        chk("ovf_before_5th", 64'(overflow), 64'd0);
        step(0, 4'b0010, 0);
        chk("ovf_after_5th", 64'(overflow[1]), 64'd1);
`ifdef STATS_ARB_DROP_COUNT_EN
        chk("ovf_drop_count", 64'(drop_count[32 +: 32]), 64'd1);
`endif
        ch1_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, '0, 1);
            if (out_valid && out_chan == 2'd1) ch1_seen++;
        end
        chk("ovf_ch1_records", 64'(ch1_seen), 64'd4);

        // ---- full FIFO popped in the same cycle as a new event ----
        step(1, '0, 0);
        for (int i = 0; i < 5; i++) step(0, 4'b0001, 0);
        step(0, 4'b0001, 1);
        chk("fullpop_overflow", 64'(overflow[0]), 64'd0);
        for (int i = 0; i < 8; i++) step(0, '0, 1);

        // ---- reset mid-stream ----
        step(0, 4'b0111, 0);
        step(0, 4'b0111, 0);
        step(1, '0, 1);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_gc", global_cycle, 64'd0);
        chk("midrst_overflow", 64'(overflow), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step(0, '0, 1);
            chk("midrst_no_stale", 64'(out_valid), 64'd0);
        end

        // ---- randomized traffic: mostly-ready phase, then congested ----
        for (int i = 0; i < 400; i++) begin
            logic [NUM_CH-1:0] v;
            v = NUM_CH'($urandom) & NUM_CH'($urandom);
            step(($urandom_range(0, 199) == 0), v, ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 400; i++) begin
            logic [NUM_CH-1:0] v;
            v = NUM_CH'($urandom);
            step(($urandom_range(0, 299) == 0), v, ($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 40; i++) step(0, '0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
